// File: rtl/multiply_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply unit: operation codes,
// widths, controller states and the operand magnitude helper.
package multiply_unit_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_ITERS  = 32;
    localparam int MUL_CNT_W  = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        MUL_MULT  = 2'b00,
        MUL_MULTU = 2'b01,
        MUL_MADD  = 2'b10,
        MUL_MSUB  = 2'b11
    } mul_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_e;

    // One extra bit so that -2^31 becomes +2^31 without wrapping.
    function automatic logic [MUL_DATA_W:0] magnitude(input logic [MUL_DATA_W-1:0] v,
                                                       input logic is_signed);
        logic [MUL_DATA_W:0] ext;
        ext = {is_signed & v[MUL_DATA_W-1], v};
        return ext[MUL_DATA_W] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/mul_datapath.sv
// Radix-2 shift-add multiplier core: captures operand magnitudes on load,
// adds one partial product per step, presents the signed result of the current step.
module mul_datapath
    import multiply_unit_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       step,
    input  logic                       is_signed,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    output logic signed [2*DATA_W-1:0] product
);

    logic [DATA_W:0]          a_mag;
    logic [DATA_W:0]          b_mag;
    logic [2*DATA_W-1:0]      mcand_p0;
    logic [DATA_W:0]          mplier_p0;
    logic [2*DATA_W-1:0]      partial_p0;
    logic                     neg_p0;
    logic [2*DATA_W-1:0]      partial_next;

    function automatic logic signed [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] mag,
                                                              input logic neg);
        return neg ? $signed(~mag + 1'b1) : $signed(mag);
    endfunction

    assign a_mag = magnitude(a, is_signed);
    assign b_mag = magnitude(b, is_signed);

    assign partial_next = partial_p0 + (mplier_p0[0] ? mcand_p0 : '0);

    // Stage p0: iteration registers, advanced once per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            partial_p0 <= '0;
        end else if (load) begin
            partial_p0 <= '0;
            mcand_p0   <= {{(DATA_W-1){1'b0}}, a_mag};
            mplier_p0  <= b_mag;
            neg_p0     <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
        end else if (step) begin
            partial_p0 <= partial_next;
            mcand_p0   <= mcand_p0 << 1;
            mplier_p0  <= mplier_p0 >> 1;
        end
    end

    // The final step's sum is consumed directly so the commit needs no extra cycle.
    assign product = apply_sign(partial_next, neg_p0);

endmodule

// File: rtl/multiply_unit.sv
// Multi-cycle MULT/MULTU/MADD/MSUB unit owning the architectural HI/LO registers;
// a two-state controller sequences the shift-add datapath and commits on the last step.
module multiply_unit
    import multiply_unit_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [MUL_DATA_W-1:0] A,
    input  logic [MUL_DATA_W-1:0] B,
    input  logic                  HiWrite,
    input  logic                  LoWrite,
    input  logic [MUL_DATA_W-1:0] WData,
    output logic                  Busy,
    output logic                  Done,
    output logic [MUL_DATA_W-1:0] Hi,
    output logic [MUL_DATA_W-1:0] Lo
);

    localparam int DATA_W = MUL_DATA_W;

    mul_state_e                  state;
    logic [MUL_CNT_W-1:0]        count;
    mul_op_e                     op_p0;
    logic                        load;
    logic                        step;
    logic                        last;
    logic signed [2*DATA_W-1:0]  product;
    logic signed [2*DATA_W-1:0]  acc;
    logic signed [2*DATA_W-1:0]  commit_val;

    assign load = (state == ST_IDLE) && Start;
    assign step = (state == ST_BUSY);
    assign last = (count == MUL_CNT_W'(MUL_ITERS - 1));

    mul_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk       (Clk),
        .reset     (Reset),
        .load      (load),
        .step      (step),
        .is_signed (mul_op_e'(Op) != MUL_MULTU),
        .a         (A),
        .b         (B),
        .product   (product)
    );

    // Accumulating ops read HI:LO as it stands at the commit edge.
    assign acc = $signed({Hi, Lo});

    always_comb begin
        commit_val = product;
        case (op_p0)
            MUL_MADD: commit_val = acc + product;
            MUL_MSUB: commit_val = acc - product;
            default:  commit_val = product;
        endcase
    end

    // Stage p0: controller, iteration count and architectural HI/LO.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            count <= '0;
            Done  <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        op_p0 <= mul_op_e'(Op);
                        count <= '0;
                        state <= ST_BUSY;
                    end else begin
                        if (HiWrite) Hi <= WData;
                        if (LoWrite) Lo <= WData;
                    end
                end
                ST_BUSY: begin
                    count <= count + 1'b1;
                    if (last) begin
                        {Hi, Lo} <= commit_val;
                        Done     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (state == ST_BUSY);

endmodule

// File: tb/tb_multiply_unit.sv
// Bench for multiply_unit: directed vector table, hand-built corner sequences,
// and random operations checked against a plain-arithmetic HI:LO model.
module tb_multiply_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;
    localparam logic [1:0] OP_MSUB  = 2'b11;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] WData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    multiply_unit dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .HiWrite (HiWrite),
        .LoWrite (LoWrite),
        .WData   (WData),
        .Busy    (Busy),
        .Done    (Done),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result of one operation from plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_commit(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        prod;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (op == OP_MULTU) prod = {32'b0, a} * {32'b0, b};
        else                prod = sa * sb;
        case (op)
            OP_MADD: return acc + prod;
            OP_MSUB: return acc - prod;
            default: return prod;
        endcase
    endfunction

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge Clk);
        HiWrite = hw;
        LoWrite = lw;
        WData   = d;
        @(negedge Clk);
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
    endtask

    // Issue one multiply (optionally with a same-cycle MTHI) and wait for completion.
    task automatic run_mul(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic hw, input logic [31:0] wd);
        int n;
        @(negedge Clk);
        Start   = 1'b1;
        Op      = op;
        A       = a;
        B       = b;
        HiWrite = hw;
        WData   = wd;
        @(negedge Clk);
        Start   = 1'b0;
        HiWrite = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge Clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'd32);
        check({name, "_done"}, 64'(Done), 64'd1);
        {m_hi, m_lo} = ref_commit(op, a, b, {m_hi, m_lo});
        check({name, "_result"}, {Hi, Lo}, {m_hi, m_lo});
        @(negedge Clk);
        check({name, "_done_clear"}, 64'(Done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int seen;

        vecs[0]  = '{"mult_neg3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'd0,        32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"multu_ones",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,       32'd0,        32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{"mult_ones",     OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,       32'd0,        32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{"mult_minmin",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'd0,       32'd0,        32'h4000_0000, 32'h0000_0000};
        vecs[4]  = '{"madd_2x3",      OP_MADD,  32'd2,         32'd3,         32'd0,       32'd10,       32'h0000_0000, 32'd16};
        vecs[5]  = '{"msub_4x5",      OP_MSUB,  32'd4,         32'd5,         32'd0,       32'd16,       32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[6]  = '{"multu_carry",   OP_MULTU, 32'h8000_0000, 32'd2,         32'd5,       32'd5,        32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{"msub_neg",      OP_MSUB,  32'hFFFF_FFFF, 32'd1,         32'd0,       32'd0,        32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{"madd_min",      OP_MADD,  32'h8000_0000, 32'd1,         32'd0,       32'd0,        32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{"mult_min_neg1", OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       32'd0,        32'h0000_0000, 32'h8000_0000};
        vecs[10] = '{"madd_wrap",     OP_MADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WData = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_hi",   64'(Hi),   64'd0);
        check("reset_lo",   64'(Lo),   64'd0);

        mt(1'b1, 1'b1, 32'hDEAD_BEEF);
        check("mt_both", {Hi, Lo}, 64'hDEAD_BEEF_DEAD_BEEF);
        mt(1'b1, 1'b0, 32'h0BAD_F00D);
        check("mthi_only", {Hi, Lo}, 64'h0BAD_F00D_DEAD_BEEF);
        mt(1'b0, 1'b1, 32'h1234_5678);
        check("mtlo_only", {Hi, Lo}, 64'h0BAD_F00D_1234_5678);

        foreach (vecs[i]) begin
            mt(1'b1, 1'b0, vecs[i].pre_hi);
            mt(1'b0, 1'b1, vecs[i].pre_lo);
            run_mul(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'd0);
            check({vecs[i].name, "_table"}, {Hi, Lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Start and MTHI in the same idle cycle: the write must be dropped.
        mt(1'b1, 1'b1, 32'd0);
        run_mul("start_with_mthi", OP_MADD, 32'd1, 32'd1, 1'b1, 32'h0000_0100);
        check("start_with_mthi_fixed", {Hi, Lo}, 64'd1);

        // Start and MTHI on the 10th busy cycle are both ignored.
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULT; A = 32'd5; B = 32'd5;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            if (n == 9) begin
                Start = 1'b1; Op = OP_MULTU; A = 32'd1; B = 32'd1;
                HiWrite = 1'b1; WData = 32'hAAAA_0000;
            end else if (n == 10) begin
                Start = 1'b0; HiWrite = 1'b0;
            end
            n++;
            @(negedge Clk);
        end
        check("busy_ignore_cycles", 64'(n), 64'd32);
        check("busy_ignore_done", 64'(Done), 64'd1);
        check("busy_ignore_result", {Hi, Lo}, 64'd25);
        @(negedge Clk);
        check("busy_ignore_no_requeue", 64'(Busy), 64'd0);
        m_hi = 32'd0; m_lo = 32'd25;

        // Reset on the 20th busy cycle abandons the multiply.
        mt(1'b1, 1'b1, 32'h5555_AAAA);
        @(negedge Clk);
        Start = 1'b1; Op = OP_MADD; A = 32'd7; B = 32'd9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) @(negedge Clk);
        check("pre_reset_busy", 64'(Busy), 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_hilo", {Hi, Lo}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done !== 1'b0 || Busy !== 1'b0) seen++;
        end
        check("midrst_no_late_done", 64'(seen), 64'd0);
        m_hi = '0; m_lo = '0;

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mt(1'b1, 1'b0, $urandom);
                mt(1'b0, 1'b1, $urandom);
            end
            run_mul($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
